// File: rtl/pipeline_pkg.sv
// Shared EX/MEM pipeline definitions: default widths, NOP opcode and the
// packed stage bundle carried from EX into MEM.
package pipeline_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_OPC_W  = 4;

  localparam logic [DEF_OPC_W-1:0] OP_NOP = '0;

  typedef struct packed {
    logic [DEF_OPC_W-1:0]  opcode;
    logic                  alu_zero;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] rf_data2;
  } ex_mem_bundle_t;

endpackage

// File: rtl/ex_mem_stage_buffer_if.sv
// EX-side and MEM-side ready/valid channels of the EX/MEM stage buffer.
interface ex_mem_stage_buffer_if #(
  parameter int unsigned DATA_W = pipeline_pkg::DEF_DATA_W,
  parameter int unsigned OPC_W  = pipeline_pkg::DEF_OPC_W
);

  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  in_opcode;
  logic              in_alu_zero;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_rf_data2;

  logic              out_valid;
  logic              out_ready;
  logic [OPC_W-1:0]  out_opcode;
  logic              out_alu_zero;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_rf_data2;

  // Environment view: EX producer plus MEM consumer.
  modport master (
    output in_valid, in_opcode, in_alu_zero, in_alu_result, in_rf_data2, out_ready,
    input  in_ready, out_valid, out_opcode, out_alu_zero, out_alu_result, out_rf_data2
  );

  // Buffer view.
  modport slave (
    input  in_valid, in_opcode, in_alu_zero, in_alu_result, in_rf_data2, out_ready,
    output in_ready, out_valid, out_opcode, out_alu_zero, out_alu_result, out_rf_data2
  );

endinterface

// File: rtl/stage_entry_reg.sv
// One buffer entry: bundle register plus valid bit. Clear beats load and
// leaves the data untouched.
module stage_entry_reg
  import pipeline_pkg::*;
#(
  parameter type T = ex_mem_bundle_t
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_clear,
  input  T     i_data,
  output logic o_valid,
  output T     o_data
);

  logic r_valid;
  T     r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ex_mem_stage_buffer.sv
// EX/MEM stage buffer: head entry, optional skid entry for a registered
// upstream ready, synchronous flush for branch/jump squash.
module ex_mem_stage_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OPC_W  = DEF_OPC_W,
  parameter int unsigned SKID   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  ex_mem_stage_buffer_if.slave  bus
);

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic              alu_zero;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] rf_data2;
  } bundle_t;

  bundle_t w_in;
  bundle_t w_head;
  bundle_t w_head_d;
  logic    w_head_valid;
  logic    w_head_load;
  logic    w_head_clear;
  logic    w_in_ready;
  logic    w_accept;
  logic    w_retire;

  assign w_in     = {bus.in_opcode, bus.in_alu_zero, bus.in_alu_result, bus.in_rf_data2};
  assign w_accept = bus.in_valid && w_in_ready;
  assign w_retire = w_head_valid && bus.out_ready;

  stage_entry_reg #(.T(bundle_t)) u_head (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_head_load),
    .i_clear (w_head_clear),
    .i_data  (w_head_d),
    .o_valid (w_head_valid),
    .o_data  (w_head)
  );

  generate
    if (SKID != 0) begin : g_skid
      bundle_t w_skid;
      logic    w_skid_valid;
      logic    w_skid_load;
      logic    w_skid_clear;

      stage_entry_reg #(.T(bundle_t)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in),
        .o_valid (w_skid_valid),
        .o_data  (w_skid)
      );

      // Ready comes straight from the skid valid flop, so MEM never reaches EX.
      assign w_in_ready = !w_skid_valid;

      // While skid is full no accept can happen, so the head refills from skid.
      always_comb begin
        w_skid_load  = !flush && w_accept && w_head_valid && !w_retire;
        w_skid_clear = flush || (w_retire && w_skid_valid);
        w_head_load  = !flush && ((w_retire && w_skid_valid) ||
                                  (w_accept && (!w_head_valid || w_retire)));
        w_head_clear = flush || (w_retire && !w_skid_valid && !w_accept);
        w_head_d     = w_skid_valid ? w_skid : w_in;
      end
    end else begin : g_single
      assign w_in_ready = !w_head_valid || bus.out_ready;

      always_comb begin
        w_head_load  = !flush && w_accept;
        w_head_clear = flush || (w_retire && !w_accept);
        w_head_d     = w_in;
      end
    end
  endgenerate

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_head_valid;
  assign bus.out_opcode     = w_head.opcode;
  assign bus.out_alu_zero   = w_head.alu_zero;
  assign bus.out_alu_result = w_head.alu_result;
  assign bus.out_rf_data2   = w_head.rf_data2;

endmodule

// File: doc/ex_mem_stage_buffer.md
Name: ex_mem_stage_buffer

Overview:
- Parametrised successor to the single-register EX/MEM latch.
- Carries the EX-stage bundle (opcode, ALU zero, ALU result, register-file read data 2) into MEM.
- Adds a per-entry valid bit, a ready/valid handshake on both sides, a synchronous flush for branch/jump squash, and an optional second (skid) entry.
- With the skid entry, the upstream ready is fully registered, so a MEM-side stall never combinationally reaches EX.

Parameters:
- DATA_W, 16, width of ALU result and RF read data 2.
- OPC_W, 4, opcode width.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with pass-through ready.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clock externally.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  EX presents a valid bundle.
- in_ready  out  1  buffer can accept this cycle.
- in_opcode  in  OPC_W  opcode from EX.
- in_alu_zero  in  1  ALU zero flag.
- in_alu_result  in  DATA_W  ALU result.
- in_rf_data2  in  DATA_W  RF read data 2 (store data).
- out_valid  out  1  head entry valid toward MEM.
- out_ready  in  1  MEM accepts head entry.
- out_opcode  out  OPC_W  head opcode.
- out_alu_zero  out  1  head ALU zero flag.
- out_alu_result  out  DATA_W  head ALU result.
- out_rf_data2  out  DATA_W  head RF data 2.

Behaviour:
- Reset (reset==0, asynchronous): all valid bits 0; all data registers 0 (opcode 0 = NOP). Outputs: out_valid=0, all out_* data=0, in_ready=1.
- Handshakes:
  - Accept = in_valid && in_ready.
  - Retire = out_valid && out_ready.
  - Data outputs are driven directly from the head registers; no combinational input-to-output path.
- Latency: an accepted bundle appears on out_* the cycle after acceptance when the buffer was empty or retiring.
- SKID=0 (single entry):
  - in_ready = !out_valid || out_ready (combinational).
  - On accept, head loads the input and head valid is set.
  - On retire without accept, head valid clears; data holds.
- SKID=1 (head + skid entry):
  - in_ready = !skid_valid (registered).
  - Accept while head empty, or while head retiring this cycle: input goes to head.
  - Accept while head valid and not retiring: input goes to skid; skid_valid set, so in_ready=0 next cycle.
  - Retire while skid_valid: skid moves to head; skid_valid clears.
  - Accept and retire in the same cycle with skid empty: head reloads with the input; occupancy unchanged.
  - Skid full and retire in the same cycle: head takes skid; in_ready=0 this cycle, so no simultaneous accept is possible.
- Ordering: strict FIFO; no entry is ever dropped or duplicated.
- Flush:
  - Synchronous; clears all valid bits next edge.
  - Overrides a simultaneous accept (input discarded) and a simultaneous retire (retire still counts for MEM this cycle, but nothing is refilled).
  - Data registers are not cleared.
  - After flush, in_ready=1 next cycle.
- Invalid entries: data fields hold their last value. Downstream must qualify on out_valid.
- Reset mid-operation: all pending entries are lost immediately; flush is irrelevant while reset==0.

Decomposition:
- Shared package pipeline_pkg:
  - DATA_W and OPC_W defaults.
  - OP_NOP constant (all zeros).
  - Packed bundle typedef ex_mem_bundle_t {opcode, alu_zero, alu_result, rf_data2}.
- One sub-module is natural: stage_entry_reg, a bundle register with valid bit, load enable, and clear. It is instantiated as head, plus skid when SKID=1.

Test Plan:
- Reset release: hold reset=0 two cycles, then 1 → out_valid=0, out_alu_result=0x0000, out_opcode=0, in_ready=1.
- Streaming: out_ready=1 constantly; accept {op=3, res=0x1234, d2=0xBEEF, z=0}, then {op=5, res=0x0000, d2=0x0001, z=1} on consecutive cycles → each appears one cycle later, in order; in_ready stays 1.
- Stall/skid (SKID=1): out_ready=0; send A (res=0x0011), then B (res=0x0022) → head=A, skid=B, in_ready=0. Raise out_ready → A retires, then B on next cycle, in_ready=1 again; no loss or duplicate.
- Same-cycle accept+retire with skid full (SKID=1) → in_ready=0 that cycle, the offered input is not taken, head=skid entry.
- Flush with simultaneous in_valid=1 while two entries are held → next cycle out_valid=0, in_ready=1; the flushed and discarded bundles never appear.
- Asynchronous reset pulse mid-cycle with head valid, res=0xFFFF → out_valid and out_alu_result go to 0 immediately, without waiting for a clock edge.
